// File: rtl/div_unit.sv
// Iterative restoring divider for the execute stage: DIV/DIVU, {HI, LO} result,
// divider stall to the hazard unit, and a flush that squashes an in-flight divide.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   remR, quoR, divR, dividendR;
    logic               negQuo, negRem, divZero;
    logic               accept, lastStep;
    logic [WIDTH:0]     shifted, trial;
    logic               take;
    logic [WIDTH-1:0]   remNext, quoNext;

    function automatic logic [WIDTH-1:0] negateIf(input logic signed [WIDTH-1:0] v,
                                                  input logic neg);
        logic signed [WIDTH-1:0] negV;
        negV = -v;
        return neg ? negV : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] signFix(input logic [WIDTH-1:0] rem,
                                                   input logic [WIDTH-1:0] quo,
                                                   input logic [WIDTH-1:0] dividend,
                                                   input logic nq, input logic nr,
                                                   input logic dz);
        // Divide by zero hands back the untouched dividend with an all-ones quotient.
        if (dz)
            return {dividend, {WIDTH{1'b1}}};
        return {negateIf(rem, nr), negateIf(quo, nq)};
    endfunction

    assign lastStep = (cnt == CNT_W'(WIDTH - 1));

    // One restoring step: shift {rem, quo} left, trial-subtract, keep if non-negative.
    always_comb begin
        shifted = {remR, quoR[WIDTH-1]};
        trial   = shifted - {1'b0, divR};
        take    = ~trial[WIDTH];
        remNext = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quoNext = {quoR[WIDTH-2:0], take};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        stall_o   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !flush_i) begin
                    stateNext = BUSY;
                    accept    = 1'b1;
                    stall_o   = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (flush_i)
                    stateNext = IDLE;
                else if (lastStep)
                    stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (rst) begin
            stall_o = 1'b0;
            accept  = 1'b0;
        end
    end

    // Accept latches magnitudes and signs; the result is loaded on the edge into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            remR      <= '0;
            quoR      <= '0;
            divR      <= '0;
            dividendR <= '0;
            negQuo    <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= '0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        remR      <= '0;
                        quoR      <= negateIf(a_i, signed_i & a_i[WIDTH-1]);
                        divR      <= negateIf(b_i, signed_i & b_i[WIDTH-1]);
                        dividendR <= a_i;
                        negQuo    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        negRem    <= signed_i & a_i[WIDTH-1];
                        divZero   <= (b_i == '0);
                    end
                end
                BUSY: begin
                    if (!flush_i) begin
                        remR <= remNext;
                        quoR <= quoNext;
                        cnt  <= cnt + CNT_W'(1);
                        if (lastStep) begin
                            result_o <= signFix(remNext, quoNext, dividendR,
                                                negQuo, negRem, divZero);
                            ready_o  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed divide scenarios plus a randomized run, all checked
// each cycle against a cycle-count/arithmetic model of the divider.
module tb_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, signed_i, flush_i;
    logic [W-1:0]  a_i, b_i;
    logic          stall_o, ready_o;
    logic [2*W-1:0] result_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checkEn = 1'b0;

    // Model: age 0 = idle, 1..W = iterating, W+1 = result cycle.
    int             mAge = 0;
    logic [W-1:0]   mA, mB;
    logic           mS;
    logic [2*W-1:0] expResult = '0;
    int             readyCycles[$];

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .stall_o(stall_o), .ready_o(ready_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [2*W-1:0] refDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        logic [W-1:0] q, r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mAge      = 0;
            expResult = '0;
        end else if (mAge == 0) begin
            if (start_i && !flush_i) begin
                mA = a_i; mB = b_i; mS = signed_i;
                mAge = 1;
            end
        end else if (mAge <= W) begin
            if (flush_i)
                mAge = 0;
            else begin
                mAge++;
                if (mAge == W + 1)
                    expResult = refDiv(mA, mB, mS);
            end
        end else begin
            mAge = 0;
        end
    end

    always @(negedge clk) begin
        logic expStall, expReady;
        if (checkEn) begin
            expStall = 1'b0;
            expReady = 1'b0;
            if (!rst) begin
                if (mAge == 0)       expStall = start_i & ~flush_i;
                else if (mAge <= W)  expStall = 1'b1;
                else                 expReady = 1'b1;
            end
            chk("stall", {63'd0, stall_o}, {63'd0, expStall});
            chk("ready", {63'd0, ready_o}, {63'd0, expReady});
            chk("result", result_o, expResult);
            if (ready_o) readyCycles.push_back(cyc);
        end
    end

    // Raises start with the given operands and waits for the result cycle; start stays high.
    task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int stallCnt, output logic [2*W-1:0] res);
        bit gotDone = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1; a_i = a; b_i = b; signed_i = s;
        stallCnt = 0;
        res = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall_o) begin
                stallCnt++;
                if (stallCnt >= 2) begin
                    a_i = $urandom; b_i = $urandom; signed_i = 1'($urandom);
                end
            end else if (ready_o) begin
                res = result_o;
                gotDone = 1'b1;
                break;
            end
        end
        chk("done_seen", {63'd0, gotDone}, 64'd1);
    endtask

    task automatic goIdle();
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    initial begin
        int sc;
        logic [2*W-1:0] res, prevRes;
        int sel;

        rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; flush_i = 1'b0; a_i = 32'd100; b_i = 32'd7;

        chk("ref_100_7", refDiv(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("ref_m7_2", refDiv(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("ref_7_m2", refDiv(32'd7, 32'hFFFF_FFFE, 1'b1), {32'd1, 32'hFFFF_FFFD});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        start_i = 1'b0;
        rst = 1'b0;
        checkEn = 1'b1;

        runDiv(32'd100, 32'd7, 1'b0, sc, res);
        chk("t1_stall_cycles", 64'(sc), 64'd33);
        chk("t1_result", res, {32'd2, 32'd14});
        goIdle();

        runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, sc, res);
        chk("t2_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        goIdle();
        runDiv(32'd7, 32'hFFFF_FFFE, 1'b1, sc, res);
        chk("t2_7_m2", res, {32'd1, 32'hFFFF_FFFD});
        goIdle();

        runDiv(32'd5, 32'd0, 1'b0, sc, res);
        chk("t3_div0_stall", 64'(sc), 64'd33);
        chk("t3_div0", res, {32'd5, 32'hFFFF_FFFF});
        goIdle();
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, sc, res);
        chk("t3_ovf", res, {32'd0, 32'h8000_0000});
        goIdle();

        prevRes = result_o;
        @(posedge clk); #1;
        start_i = 1'b1; a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        chk("t4_stall_flushcyc", {63'd0, stall_o}, 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("t4_stall_after", {63'd0, stall_o}, 64'd0);
        readyCycles.delete();
        repeat (35) @(posedge clk);
        chk("t4_no_ready", 64'(readyCycles.size()), 64'd0);
        chk("t4_result_kept", result_o, prevRes);
        runDiv(32'd9, 32'd3, 1'b0, sc, res);
        chk("t4_9_3_stall", 64'(sc), 64'd33);
        chk("t4_9_3", res, {32'd0, 32'd3});
        goIdle();

        readyCycles.delete();
        runDiv(32'd100, 32'd7, 1'b0, sc, res);
        chk("t5_first", res, {32'd2, 32'd14});
        runDiv(32'd20, 32'd6, 1'b0, sc, res);
        chk("t5_second", res, {32'd2, 32'd3});
        goIdle();
        chk("t5_pulses", 64'(readyCycles.size()), 64'd2);
        if (readyCycles.size() == 2)
            chk("t5_spacing", 64'(readyCycles[1] - readyCycles[0]), 64'd34);

        @(posedge clk); #1;
        start_i = 1'b1; a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_stall", {63'd0, stall_o}, 64'd0);
        chk("t6_ready", {63'd0, ready_o}, 64'd0);
        chk("t6_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        runDiv(32'd100, 32'd7, 1'b0, sc, res);
        chk("t6_after", res, {32'd2, 32'd14});
        goIdle();

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start_i  = ($urandom % 4) != 0;
            flush_i  = ($urandom % 40) == 0;
            signed_i = 1'($urandom);
            sel = int'($urandom % 8);
            a_i = $urandom;
            case (sel)
                0: b_i = '0;
                1: begin a_i = 32'h8000_0000; b_i = 32'hFFFF_FFFF; signed_i = 1'b1; end
                2: b_i = $urandom_range(1, 15);
                default: b_i = $urandom;
            endcase
        end
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        repeat (40) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
